// File: rtl/frame_sync_tracker_pkg.sv
// Shared sizing, state encoding and helpers for the frame sync tracker.
// Weight width follows the correlator's saturation range.
package frame_sync_tracker_pkg;
   localparam int BITS_PER_FRAME = 80;
   localparam int NUM_FRAMES     = 32;
   localparam int MAX_CORR_VAL   = 256;

   function automatic int weight_w(input int max_val);
      return $clog2(max_val);
   endfunction

   localparam int W       = weight_w(MAX_CORR_VAL);
   localparam int PTR_W   = 7;
   localparam int FRAME_W = $clog2(NUM_FRAMES);

   typedef enum logic [1:0] {CLEAR, ACCUM, LOCKED} sync_state_t;

   typedef struct packed {
      logic [PTR_W-1:0] pos;
      logic [W-1:0]     w;
   } peak_t;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(BITS_PER_FRAME - 1)) ? '0 : p + PTR_W'(1);
   endfunction
endpackage

// File: rtl/frame_sync_tracker_if.sv
// Correlator-side and lock-status signals of the frame sync tracker.
// master = upstream correlator/controller, slave = the tracker.
interface frame_sync_tracker_if;
   import frame_sync_tracker_pkg::*;

   logic               bit_valid_in;
   logic [W-1:0]       past_weight_out;
   logic               corr_valid_in;
   logic [W-1:0]       corr_weight_in;
   logic               relock_in;
   logic               ready_out;
   logic               lock_out;
   logic               lock_valid_out;
   logic               lock_fail_out;
   logic [PTR_W-1:0]   offset_out;
   logic [W-1:0]       peak_out;
   logic               frame_start_out;

   modport master (
      output bit_valid_in, corr_valid_in, corr_weight_in, relock_in,
      input  past_weight_out, ready_out, lock_out, lock_valid_out, lock_fail_out,
             offset_out, peak_out, frame_start_out
   );

   modport slave (
      input  bit_valid_in, corr_valid_in, corr_weight_in, relock_in,
      output past_weight_out, ready_out, lock_out, lock_valid_out, lock_fail_out,
             offset_out, peak_out, frame_start_out
   );
endinterface

// File: rtl/frame_sync_tracker_weight_ram.sv
// Per-position weight store: one synchronous write port, one combinational read port.
// A same-cycle read of the address being written returns the value held before the write.
module frame_sync_tracker_weight_ram
   import frame_sync_tracker_pkg::*;
(
   input  logic             clk,
   input  logic             we,
   input  logic [PTR_W-1:0] wr_addr,
   input  logic [W-1:0]     wr_dat,
   input  logic [PTR_W-1:0] rd_addr,
   output logic [W-1:0]     rd_dat
);
   logic [W-1:0] mem [BITS_PER_FRAME];

   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_dat;
   end

   assign rd_dat = mem[rd_addr];
endmodule

// File: rtl/frame_sync_tracker.sv
// Weight store, final-frame peak search and lock tracking around the frame correlator.
// past_weight is combinational, status pulses are registered 1 cycle; ready_out stays low while the store clears.
module frame_sync_tracker
   import frame_sync_tracker_pkg::*;
#(
   parameter int LOCK_THRESH = 200
) (
   input logic clk,
   input logic sys_rst,
   frame_sync_tracker_if.slave bus
);
   sync_state_t      state, state_nxt;
   logic [PTR_W-1:0] clr_ptr, rd_ptr, wr_ptr, ram_addr;
   logic [FRAME_W-1:0] frame_cnt;
   peak_t            best, cand, lock_res;
   logic [W-1:0]     ram_wr_dat, ram_rd_dat;
   logic             ram_we, ready, running, wr_fire, rd_fire, wr_last;
   logic             search, cand_hit, decide, lock_ok;
   logic             lock_q, lock_valid_q, lock_fail_q, frame_start_q;

   assign running  = (state != CLEAR);
   assign wr_fire  = running && bus.corr_valid_in;
   assign rd_fire  = running && bus.bit_valid_in;
   assign wr_last  = (wr_ptr == PTR_W'(BITS_PER_FRAME - 1));
   assign search   = (state == ACCUM) && wr_fire && (frame_cnt == FRAME_W'(NUM_FRAMES - 1));
   assign cand_hit = search && (bus.corr_weight_in > best.w);
   // The decision must see the final write of the frame, so it judges the candidate, not best.
   assign decide   = search && wr_last && !bus.relock_in;
   assign lock_ok  = (cand.w >= W'(LOCK_THRESH));

   always_comb begin
      cand = best;
      if (cand_hit) begin
         cand.pos = wr_ptr;
         cand.w   = bus.corr_weight_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!sys_rst) state <= CLEAR;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (bus.relock_in) begin
         state_nxt = CLEAR;
      end else begin
         case (state)
            CLEAR:   if (clr_ptr == PTR_W'(BITS_PER_FRAME - 1)) state_nxt = ACCUM;
            ACCUM:   if (decide) state_nxt = lock_ok ? LOCKED : CLEAR;
            LOCKED:  state_nxt = LOCKED;
            default: state_nxt = CLEAR;
         endcase
      end
   end

   always_comb begin
      ready      = 1'b0;
      ram_we     = wr_fire;
      ram_addr   = wr_ptr;
      ram_wr_dat = bus.corr_weight_in;
      case (state)
         CLEAR: begin
            ram_we     = 1'b1;
            ram_addr   = clr_ptr;
            ram_wr_dat = '0;
         end
         ACCUM, LOCKED: ready = 1'b1;
         default: ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!sys_rst) begin
         clr_ptr       <= '0;
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         frame_cnt     <= '0;
         best          <= '0;
         lock_res      <= '0;
         lock_q        <= 1'b0;
         lock_valid_q  <= 1'b0;
         lock_fail_q   <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         lock_valid_q  <= 1'b0;
         lock_fail_q   <= 1'b0;
         frame_start_q <= 1'b0;
         if (state_nxt == CLEAR) begin
            clr_ptr     <= (state == CLEAR && !bus.relock_in) ? ptr_inc(clr_ptr) : '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            frame_cnt   <= '0;
            best        <= '0;
            lock_res    <= '0;
            lock_q      <= 1'b0;
            lock_fail_q <= decide && !lock_ok;
         end else begin
            clr_ptr <= '0;
            if (rd_fire) rd_ptr <= ptr_inc(rd_ptr);
            if (wr_fire) begin
               wr_ptr <= ptr_inc(wr_ptr);
               if (wr_last) frame_cnt <= frame_cnt + FRAME_W'(1);
            end
            if (cand_hit) best <= cand;
            if (decide) begin
               lock_q       <= 1'b1;
               lock_valid_q <= 1'b1;
               lock_res     <= cand;
            end
            frame_start_q <= (state == LOCKED) && wr_fire && (wr_ptr == lock_res.pos);
         end
      end
   end

   frame_sync_tracker_weight_ram u_ram (
      .clk     (clk),
      .we      (ram_we),
      .wr_addr (ram_addr),
      .wr_dat  (ram_wr_dat),
      .rd_addr (rd_ptr),
      .rd_dat  (ram_rd_dat)
   );

   assign bus.past_weight_out = running ? ram_rd_dat : '0;
   assign bus.ready_out       = ready;
   assign bus.lock_out        = lock_q;
   assign bus.lock_valid_out  = lock_valid_q;
   assign bus.lock_fail_out   = lock_fail_q;
   assign bus.offset_out      = lock_res.pos;
   assign bus.peak_out        = lock_res.w;
   assign bus.frame_start_out = frame_start_q;
endmodule

// File: tb/tb_frame_sync_tracker.sv
// Bench for frame_sync_tracker: directed phases with randomized traffic, checked against a
// frame-level model (weight array, final-frame maximum, expected pulses).
module tb_frame_sync_tracker;
   import frame_sync_tracker_pkg::*;

   localparam int THRESH     = 200;
   localparam int ACQ_WRITES = BITS_PER_FRAME * NUM_FRAMES;

   logic clk = 1'b0;
   logic sys_rst = 1'b0;
   always #5 clk = ~clk;

   frame_sync_tracker_if bus ();

   frame_sync_tracker #(.LOCK_THRESH(THRESH)) dut (
      .clk     (clk),
      .sys_rst (sys_rst),
      .bus     (bus)
   );

   int tests = 0;
   int fails = 0;
   int m_mem [BITS_PER_FRAME];
   int ff_w  [BITS_PER_FRAME];
   int m_rd, m_wr, m_acq, m_off, m_peak;
   bit m_run, m_locked;
   int n_lv, n_lf, n_fs;
   bit s_lv, s_lf;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   function automatic int nxt(input int p);
      return (p + 1) % BITS_PER_FRAME;
   endfunction

   function automatic void model_clear();
      foreach (m_mem[i]) m_mem[i] = 0;
      m_rd = 0; m_wr = 0; m_acq = 0; m_run = 1'b1; m_locked = 1'b0;
   endfunction

   function automatic void find_peak();
      m_peak = 0; m_off = 0;
      for (int i = 0; i < BITS_PER_FRAME; i++)
         if (ff_w[i] > m_peak) begin m_peak = ff_w[i]; m_off = i; end
   endfunction

   function automatic logic [W-1:0] gen_w(input int mode, input int f, input int p);
      logic [W-1:0] r;
      case (mode)
         0: r = W'(p + 176);
         1: r = W'(10);
         2: begin
            if (f == NUM_FRAMES - 1) r = (p == 17 || p == 42) ? W'(250) : W'(0);
            else                     r = W'($urandom_range(0, 255));
         end
         default: r = W'($urandom_range(0, 255));
      endcase
      return r;
   endfunction

   task automatic cycle(input logic bv, input logic cv, input logic [W-1:0] cw, input logic rl);
      bit exp_lv, exp_lf, exp_fs, run0;
      exp_lv = 1'b0; exp_lf = 1'b0; run0 = m_run;
      bus.bit_valid_in = bv; bus.corr_valid_in = cv; bus.corr_weight_in = cw; bus.relock_in = rl;
      #1;
      if (run0) check("past_weight", 32'(bus.past_weight_out), m_mem[m_rd]);
      exp_fs = run0 && m_locked && cv && !rl && (m_wr == m_off);
      if (run0 && bv) m_rd = nxt(m_rd);
      if (run0 && cv) begin
         if (!m_locked) begin
            if (m_acq >= ACQ_WRITES - BITS_PER_FRAME) ff_w[m_wr] = int'(cw);
            if (m_acq == ACQ_WRITES - 1 && !rl) begin
               find_peak();
               if (m_peak >= THRESH) begin exp_lv = 1'b1; m_locked = 1'b1; end
               else begin exp_lf = 1'b1; m_run = 1'b0; end
            end
            m_acq++;
         end
         m_mem[m_wr] = int'(cw);
         m_wr = nxt(m_wr);
      end
      if (rl) begin m_run = 1'b0; m_locked = 1'b0; end
      @(posedge clk); #1;
      s_lv = bus.lock_valid_out; s_lf = bus.lock_fail_out;
      if (s_lv) n_lv++;
      if (s_lf) n_lf++;
      if (bus.frame_start_out === 1'b1) n_fs++;
      check("lock_valid", 32'(bus.lock_valid_out), 32'(exp_lv));
      check("lock_fail", 32'(bus.lock_fail_out), 32'(exp_lf));
      check("frame_start", 32'(bus.frame_start_out), 32'(exp_fs));
      check("ready", 32'(bus.ready_out), 32'(m_run));
      check("lock_out", 32'(bus.lock_out), 32'(m_locked));
   endtask

   task automatic wait_clear(input string tag);
      int n = 0;
      while (bus.ready_out !== 1'b1 && n < 200) begin
         bus.bit_valid_in   = 1'($urandom_range(0, 1));
         bus.corr_valid_in  = 1'($urandom_range(0, 1));
         bus.corr_weight_in = W'($urandom_range(0, 255));
         bus.relock_in      = 1'b0;
         @(posedge clk); #1;
         n++;
      end
      bus.bit_valid_in = 1'b0; bus.corr_valid_in = 1'b0;
      check(tag, n, BITS_PER_FRAME);
      model_clear();
   endtask

   task automatic do_reset(input int ncyc);
      bus.bit_valid_in = 1'b0; bus.corr_valid_in = 1'b0; bus.corr_weight_in = '0; bus.relock_in = 1'b0;
      sys_rst = 1'b0;
      repeat (ncyc) @(posedge clk);
      #1;
      check("rst_ready", 32'(bus.ready_out), 0);
      check("rst_lock", 32'(bus.lock_out), 0);
      check("rst_lock_valid", 32'(bus.lock_valid_out), 0);
      check("rst_lock_fail", 32'(bus.lock_fail_out), 0);
      check("rst_offset", 32'(bus.offset_out), 0);
      check("rst_peak", 32'(bus.peak_out), 0);
      check("rst_frame_start", 32'(bus.frame_start_out), 0);
      check("rst_past_weight", 32'(bus.past_weight_out), 0);
      sys_rst = 1'b1; m_run = 1'b0; m_locked = 1'b0;
      wait_clear("clear_len_after_rst");
   endtask

   task automatic acquire(input int mode, input bit relock_last, input bit rand_rd);
      for (int f = 0; f < NUM_FRAMES; f++) begin
         for (int p = 0; p < BITS_PER_FRAME; p++) begin
            if ($urandom_range(0, 7) == 0)
               cycle(rand_rd ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, '0, 1'b0);
            cycle(rand_rd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b1, gen_w(mode, f, p),
                  relock_last && f == NUM_FRAMES - 1 && p == BITS_PER_FRAME - 1);
         end
      end
   endtask

   initial begin
      int idx, old_w;
      bus.bit_valid_in = 1'b0; bus.corr_valid_in = 1'b0; bus.corr_weight_in = '0; bus.relock_in = 1'b0;
      m_run = 1'b0; m_locked = 1'b0; m_off = 0;
      n_lv = 0; n_lf = 0; n_fs = 0;

      do_reset(3);
      for (int i = 0; i < BITS_PER_FRAME; i++) cycle(1'b1, 1'b0, '0, 1'b0);

      // Strictly rising weights: the last position wins.
      n_lv = 0; n_lf = 0;
      acquire(0, 1'b0, 1'b0);
      check("t2_lock_valid_last", 32'(s_lv), 1);
      check("t2_lock_pulses", n_lv, 1);
      check("t2_fail_pulses", n_lf, 0);
      check("t2_offset", 32'(bus.offset_out), 79);
      check("t2_peak", 32'(bus.peak_out), 255);
      cycle(1'b0, 1'b0, '0, 1'b1);
      wait_clear("t2_relock_clear_len");

      n_lv = 0; n_lf = 0;
      acquire(1, 1'b0, 1'b1);
      check("t3_fail_last", 32'(s_lf), 1);
      check("t3_fail_pulses", n_lf, 1);
      check("t3_lock_pulses", n_lv, 0);
      wait_clear("t3_clear_len");

      n_lv = 0;
      acquire(2, 1'b0, 1'b1);
      check("t4_lock_pulses", n_lv, 1);
      check("t4_offset", 32'(bus.offset_out), 17);
      check("t4_peak", 32'(bus.peak_out), 250);
      n_fs = 0;
      for (int i = 0; i < 3 * BITS_PER_FRAME; i++)
         cycle(1'($urandom_range(0, 1)), 1'b1, W'($urandom_range(0, 255)), 1'b0);
      check("t4_frame_starts", n_fs, 3);

      for (int p = 0; p < BITS_PER_FRAME; p++)
         cycle(1'b0, 1'b1, (p == 5) ? W'(8'h55) : W'($urandom_range(0, 255)), 1'b0);
      for (int i = 0; i < BITS_PER_FRAME && m_rd != 5; i++) cycle(1'b1, 1'b0, '0, 1'b0);
      bus.bit_valid_in = 1'b1; bus.corr_valid_in = 1'b0;
      #1;
      check("t5_read_back_55", 32'(bus.past_weight_out), 32'h55);
      cycle(1'b1, 1'b0, '0, 1'b0);
      for (int i = 0; i < BITS_PER_FRAME && m_wr != m_rd; i++)
         cycle(1'b0, 1'b1, W'($urandom_range(0, 255)), 1'b0);
      idx = m_rd; old_w = m_mem[idx];
      bus.bit_valid_in = 1'b1; bus.corr_valid_in = 1'b1; bus.corr_weight_in = W'(8'hAA);
      #1;
      check("t5_same_cycle_old", 32'(bus.past_weight_out), old_w);
      cycle(1'b1, 1'b1, W'(8'hAA), 1'b0);
      for (int i = 0; i < BITS_PER_FRAME && m_rd != idx; i++) cycle(1'b1, 1'b0, '0, 1'b0);
      check("t5_same_cycle_new", 32'(bus.past_weight_out), 32'hAA);
      cycle(1'b0, 1'b0, '0, 1'b1);
      check("t5_relock_lock_out", 32'(bus.lock_out), 0);
      wait_clear("t5_relock_clear_len");

      n_lv = 0; n_lf = 0;
      acquire(3, 1'b1, 1'b1);
      check("t6_no_lock_pulse", n_lv, 0);
      check("t6_no_fail_pulse", n_lf, 0);
      check("t6_in_clear", 32'(bus.ready_out), 0);
      wait_clear("t6_clear_len");
      for (int i = 0; i < 100; i++)
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom_range(0, 255)), 1'b0);
      do_reset(1);

      n_lv = 0; n_lf = 0;
      acquire(3, 1'b0, 1'b1);
      check("t7_one_decision", n_lv + n_lf, 1);
      if (m_locked) begin
         check("t7_offset", 32'(bus.offset_out), m_off);
         check("t7_peak", 32'(bus.peak_out), m_peak);
      end else begin
         wait_clear("t7_clear_len");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog expired");
   end
endmodule
